// File: rtl/kmeans_centroid_update_k7.sv
// k-means centroid update: snapshots per-cluster sums/counts on a strobe, runs one shared
// 16-step restoring divider over all 21 quotients, then commits the new centroid set at once.
module kmeans_centroid_update_k7 #(
  parameter logic [55:0] INIT_CX = 56'hD0_B0_90_70_50_30_10,
  parameter logic [55:0] INIT_CY = 56'hD0_B0_90_70_50_30_10,
  parameter logic [55:0] INIT_CZ = 56'hD0_B0_90_70_50_30_10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        update_centroids,
  input  logic [15:0] sumx0, sumx1, sumx2, sumx3, sumx4, sumx5, sumx6,
  input  logic [15:0] sumy0, sumy1, sumy2, sumy3, sumy4, sumy5, sumy6,
  input  logic [15:0] sumz0, sumz1, sumz2, sumz3, sumz4, sumz5, sumz6,
  input  logic [5:0]  cnt0, cnt1, cnt2, cnt3, cnt4, cnt5, cnt6,
  output logic [7:0]  cx0, cx1, cx2, cx3, cx4, cx5, cx6,
  output logic [7:0]  cy0, cy1, cy2, cy3, cy4, cy5, cy6,
  output logic [7:0]  cz0, cz1, cz2, cz3, cz4, cz5, cz6,
  output logic        busy,
  output logic        upd_done,
  output logic        changed,
  output logic        overrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] w_sum_in [21];
  logic [5:0]  w_cnt_in [7];
  logic [15:0] r_sum [21];
  logic [5:0]  r_cnt [7];
  logic [4:0]  r_j;
  logic [2:0]  r_clu;
  logic [1:0]  r_axis;
  logic [16:0] r_rem;
  logic [15:0] r_dvd;
  logic [15:0] r_quo;
  logic [5:0]  r_div;
  logic [4:0]  r_bitcnt;
  logic [7:0]  r_cx [7];
  logic [7:0]  r_cy [7];
  logic [7:0]  r_cz [7];
  logic [7:0]  r_pend [21];
  logic        r_busy, r_upd_done, r_changed, r_overrun;
  logic [17:0] w_rem_sh;
  logic        w_ge;
  logic [7:0]  w_cur_all [21];
  logic [7:0]  w_result;
  logic [7:0]  w_commit [21];
  logic        w_changed;

  // Slot order is cluster-major, x/y/z within a cluster: slot j = 3*cluster + axis.
  assign w_sum_in[0]  = sumx0; assign w_sum_in[1]  = sumy0; assign w_sum_in[2]  = sumz0;
  assign w_sum_in[3]  = sumx1; assign w_sum_in[4]  = sumy1; assign w_sum_in[5]  = sumz1;
  assign w_sum_in[6]  = sumx2; assign w_sum_in[7]  = sumy2; assign w_sum_in[8]  = sumz2;
  assign w_sum_in[9]  = sumx3; assign w_sum_in[10] = sumy3; assign w_sum_in[11] = sumz3;
  assign w_sum_in[12] = sumx4; assign w_sum_in[13] = sumy4; assign w_sum_in[14] = sumz4;
  assign w_sum_in[15] = sumx5; assign w_sum_in[16] = sumy5; assign w_sum_in[17] = sumz5;
  assign w_sum_in[18] = sumx6; assign w_sum_in[19] = sumy6; assign w_sum_in[20] = sumz6;
  assign w_cnt_in[0] = cnt0; assign w_cnt_in[1] = cnt1; assign w_cnt_in[2] = cnt2;
  assign w_cnt_in[3] = cnt3; assign w_cnt_in[4] = cnt4; assign w_cnt_in[5] = cnt5;
  assign w_cnt_in[6] = cnt6;

  assign w_rem_sh = {r_rem, r_dvd[15]};
  assign w_ge     = (w_rem_sh >= {12'd0, r_div});

  always_comb begin
    for (int i = 0; i < 7; i++) begin
      w_cur_all[3*i]     = r_cx[i];
      w_cur_all[3*i + 1] = r_cy[i];
      w_cur_all[3*i + 2] = r_cz[i];
    end
  end

  // An empty cluster keeps its current coordinate; large quotients clamp to 8'hFF.
  always_comb begin
    w_result = w_cur_all[r_j];
    if (r_div == 6'd0) begin
      w_result = w_cur_all[r_j];
    end else if (r_quo[15:8] != 8'd0) begin
      w_result = 8'hFF;
    end else begin
      w_result = r_quo[7:0];
    end
  end

  // The last slot is written on the commit edge itself, so merge it in here.
  always_comb begin
    w_changed = 1'b0;
    for (int k = 0; k < 21; k++) begin
      w_commit[k] = (r_j == 5'(k)) ? w_result : r_pend[k];
      w_changed   = w_changed | (w_commit[k] != w_cur_all[k]);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = update_centroids ? S_LOAD : S_IDLE;
      S_LOAD:  w_state_nxt = S_SHIFT;
      S_SHIFT: w_state_nxt = (r_bitcnt == 5'd1) ? S_WRITE : S_SHIFT;
      S_WRITE: w_state_nxt = (r_j == 5'd20) ? S_IDLE : S_LOAD;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 7; i++) begin
        r_cx[i]  <= INIT_CX[8*i +: 8];
        r_cy[i]  <= INIT_CY[8*i +: 8];
        r_cz[i]  <= INIT_CZ[8*i +: 8];
        r_cnt[i] <= 6'd0;
      end
      for (int k = 0; k < 21; k++) begin
        r_sum[k]  <= 16'd0;
        r_pend[k] <= 8'd0;
      end
      r_j        <= 5'd0;
      r_clu      <= 3'd0;
      r_axis     <= 2'd0;
      r_rem      <= 17'd0;
      r_dvd      <= 16'd0;
      r_quo      <= 16'd0;
      r_div      <= 6'd0;
      r_bitcnt   <= 5'd0;
      r_busy     <= 1'b0;
      r_upd_done <= 1'b0;
      r_changed  <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_upd_done <= 1'b0;
      r_busy     <= (w_state_nxt != S_IDLE);
      if (update_centroids && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (update_centroids) begin
            for (int k = 0; k < 21; k++) r_sum[k] <= w_sum_in[k];
            for (int i = 0; i < 7; i++)  r_cnt[i] <= w_cnt_in[i];
            r_j    <= 5'd0;
            r_clu  <= 3'd0;
            r_axis <= 2'd0;
          end
        end
        S_LOAD: begin
          r_rem    <= 17'd0;
          r_dvd    <= r_sum[r_j];
          r_div    <= r_cnt[r_clu];
          r_quo    <= 16'd0;
          r_bitcnt <= 5'd16;
        end
        S_SHIFT: begin
          r_rem    <= w_ge ? 17'(w_rem_sh - {12'd0, r_div}) : w_rem_sh[16:0];
          r_quo    <= {r_quo[14:0], w_ge};
          r_dvd    <= {r_dvd[14:0], 1'b0};
          r_bitcnt <= r_bitcnt - 5'd1;
        end
        S_WRITE: begin
          r_pend[r_j] <= w_result;
          if (r_j == 5'd20) begin
            for (int i = 0; i < 7; i++) begin
              r_cx[i] <= w_commit[3*i];
              r_cy[i] <= w_commit[3*i + 1];
              r_cz[i] <= w_commit[3*i + 2];
            end
            r_changed  <= w_changed;
            r_upd_done <= 1'b1;
          end else begin
            r_j <= r_j + 5'd1;
            if (r_axis == 2'd2) begin
              r_axis <= 2'd0;
              r_clu  <= r_clu + 3'd1;
            end else begin
              r_axis <= r_axis + 2'd1;
            end
          end
        end
        default: begin
          r_j <= 5'd0;
        end
      endcase
    end
  end

  assign cx0 = r_cx[0]; assign cx1 = r_cx[1]; assign cx2 = r_cx[2]; assign cx3 = r_cx[3];
  assign cx4 = r_cx[4]; assign cx5 = r_cx[5]; assign cx6 = r_cx[6];
  assign cy0 = r_cy[0]; assign cy1 = r_cy[1]; assign cy2 = r_cy[2]; assign cy3 = r_cy[3];
  assign cy4 = r_cy[4]; assign cy5 = r_cy[5]; assign cy6 = r_cy[6];
  assign cz0 = r_cz[0]; assign cz1 = r_cz[1]; assign cz2 = r_cz[2]; assign cz3 = r_cz[3];
  assign cz4 = r_cz[4]; assign cz5 = r_cz[5]; assign cz6 = r_cz[6];
  assign busy     = r_busy;
  assign upd_done = r_upd_done;
  assign changed  = r_changed;
  assign overrun  = r_overrun;

endmodule

// File: tb/tb_kmeans_centroid_update_k7.sv
// Directed bench for kmeans_centroid_update_k7: expected commits are queued at the strobe
// and a negedge monitor checks each upd_done pulse against the head of the queue.
module tb_kmeans_centroid_update_k7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        update_centroids = 1'b0;
  logic [15:0] sx [7];
  logic [15:0] sy [7];
  logic [15:0] sz [7];
  logic [5:0]  cn [7];
  logic [7:0]  cx [7];
  logic [7:0]  cy [7];
  logic [7:0]  cz [7];
  logic        busy, upd_done, changed, overrun;

  typedef struct {
    logic [167:0] cent;
    logic         chg;
    int           done;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] ex [7];
  logic [7:0] ey [7];
  logic [7:0] ez [7];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  kmeans_centroid_update_k7 dut (
    .clk(clk), .rst_n(rst_n), .update_centroids(update_centroids),
    .sumx0(sx[0]), .sumx1(sx[1]), .sumx2(sx[2]), .sumx3(sx[3]), .sumx4(sx[4]), .sumx5(sx[5]), .sumx6(sx[6]),
    .sumy0(sy[0]), .sumy1(sy[1]), .sumy2(sy[2]), .sumy3(sy[3]), .sumy4(sy[4]), .sumy5(sy[5]), .sumy6(sy[6]),
    .sumz0(sz[0]), .sumz1(sz[1]), .sumz2(sz[2]), .sumz3(sz[3]), .sumz4(sz[4]), .sumz5(sz[5]), .sumz6(sz[6]),
    .cnt0(cn[0]), .cnt1(cn[1]), .cnt2(cn[2]), .cnt3(cn[3]), .cnt4(cn[4]), .cnt5(cn[5]), .cnt6(cn[6]),
    .cx0(cx[0]), .cx1(cx[1]), .cx2(cx[2]), .cx3(cx[3]), .cx4(cx[4]), .cx5(cx[5]), .cx6(cx[6]),
    .cy0(cy[0]), .cy1(cy[1]), .cy2(cy[2]), .cy3(cy[3]), .cy4(cy[4]), .cy5(cy[5]), .cy6(cy[6]),
    .cz0(cz[0]), .cz1(cz[1]), .cz2(cz[2]), .cz3(cz[3]), .cz4(cz[4]), .cz5(cz[5]), .cz6(cz[6]),
    .busy(busy), .upd_done(upd_done), .changed(changed), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [167:0] pack_exp();
    logic [167:0] v;
    v = '0;
    for (int k = 0; k < 7; k++) begin
      v[8*k +: 8]       = ex[k];
      v[56 + 8*k +: 8]  = ey[k];
      v[112 + 8*k +: 8] = ez[k];
    end
    return v;
  endfunction

  function automatic logic [167:0] pack_dut();
    logic [167:0] v;
    v = '0;
    for (int k = 0; k < 7; k++) begin
      v[8*k +: 8]       = cx[k];
      v[56 + 8*k +: 8]  = cy[k];
      v[112 + 8*k +: 8] = cz[k];
    end
    return v;
  endfunction

  task automatic check(input string name, input logic [167:0] act, input logic [167:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic set_init();
    ex = '{8'h10, 8'h30, 8'h50, 8'h70, 8'h90, 8'hB0, 8'hD0};
    ey = '{8'h10, 8'h30, 8'h50, 8'h70, 8'h90, 8'hB0, 8'hD0};
    ez = '{8'h10, 8'h30, 8'h50, 8'h70, 8'h90, 8'hB0, 8'hD0};
  endtask

  // Empty clusters get nonzero junk sums to prove a zero count leaves the centroid alone.
  task automatic clear_in();
    for (int k = 0; k < 7; k++) begin
      sx[k] = 16'h1234;
      sy[k] = 16'h0BEE;
      sz[k] = 16'hFFFF;
      cn[k] = 6'd0;
    end
  endtask

  task automatic strobe(input bit push, input bit chg);
    exp_t e;
    @(negedge clk);
    update_centroids = 1'b1;
    @(posedge clk);
    #1;
    if (push) begin
      e.cent = pack_exp();
      e.chg  = chg;
      e.done = cyc + 378;
      sb.push_back(e);
    end
    @(negedge clk);
    update_centroids = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 600 && sb.size() > 0; i++) @(negedge clk);
    check("drain_timeout", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: every upd_done must match the oldest queued expectation.
  always @(negedge clk) begin
    if (sb.size() > 0 && cyc == sb[0].done - 1) check("busy_before_done", busy, 1'b1);
    if (upd_done) begin
      if (sb.size() == 0) begin
        check("unexpected_upd_done", upd_done, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_cycle", cyc, e.done);
        check("busy_at_done", busy, 1'b0);
        check("centroids", pack_dut(), e.cent);
        check("changed", changed, e.chg);
      end
    end
  end

  initial begin
    clear_in();
    set_init();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_cx0", cx[0], 8'h10);
    check("rst_cx6", cx[6], 8'hD0);
    check("rst_cy6", cy[6], 8'hD0);
    check("rst_cz0", cz[0], 8'h10);
    check("rst_all", pack_dut(), pack_exp());
    check("rst_busy", busy, 1'b0);
    check("rst_upd_done", upd_done, 1'b0);
    check("rst_changed", changed, 1'b0);
    check("rst_overrun", overrun, 1'b0);

    // Cluster 0 only: 1000/10, 500/10, 41/10 truncates to 4.
    clear_in();
    cn[0] = 6'd10; sx[0] = 16'd1000; sy[0] = 16'd500; sz[0] = 16'd41;
    ex[0] = 8'd100; ey[0] = 8'd50; ez[0] = 8'd4;
    strobe(1'b1, 1'b1);
    wait_drain();

    strobe(1'b1, 1'b0);
    wait_drain();

    // 10455/41 = 255 exactly; 327/41 = 7; 0/41 = 0.
    clear_in();
    cn[3] = 6'd41; sx[3] = 16'd10455; sy[3] = 16'd327; sz[3] = 16'd0;
    ex[3] = 8'hFF; ey[3] = 8'd7; ez[3] = 8'd0;
    strobe(1'b1, 1'b1);
    wait_drain();

    // Saturation with count 1, plus count 63 on the last cluster.
    clear_in();
    cn[3] = 6'd1;  sx[3] = 16'd600;   sy[3] = 16'd200;  sz[3] = 16'd256;
    cn[6] = 6'd63; sx[6] = 16'd65535; sy[6] = 16'd3969; sz[6] = 16'd62;
    ex[3] = 8'hFF; ey[3] = 8'hC8; ez[3] = 8'hFF;
    ex[6] = 8'hFF; ey[6] = 8'h3F; ez[6] = 8'h00;
    strobe(1'b1, 1'b1);
    wait_drain();

    // Second strobe mid-sequence with different data must be ignored.
    clear_in();
    cn[1] = 6'd2; sx[1] = 16'd10; sy[1] = 16'd20; sz[1] = 16'd30;
    ex[1] = 8'd5; ey[1] = 8'd10; ez[1] = 8'd15;
    strobe(1'b1, 1'b1);
    repeat (98) @(negedge clk);
    cn[1] = 6'd1; sx[1] = 16'd99; sy[1] = 16'd99; sz[1] = 16'd99;
    cn[0] = 6'd1; sx[0] = 16'd1;  sy[0] = 16'd1;  sz[0] = 16'd1;
    strobe(1'b0, 1'b0);
    check("overrun_set", overrun, 1'b1);
    check("busy_mid", busy, 1'b1);
    wait_drain();
    check("overrun_sticky", overrun, 1'b1);

    // Reset mid-sequence: no commit, back to initial centroids.
    clear_in();
    cn[2] = 6'd4; sx[2] = 16'd40; sy[2] = 16'd0; sz[2] = 16'd1023;
    strobe(1'b0, 1'b0);
    repeat (198) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    set_init();
    check("abort_busy", busy, 1'b0);
    check("abort_overrun", overrun, 1'b0);
    check("abort_changed", changed, 1'b0);
    check("abort_cent", pack_dut(), pack_exp());
    rst_n = 1'b1;
    repeat (400) @(negedge clk);
    check("abort_no_change", pack_dut(), pack_exp());

    ex[2] = 8'd10; ey[2] = 8'd0; ez[2] = 8'hFF;
    strobe(1'b1, 1'b1);
    wait_drain();
    check("final_overrun", overrun, 1'b0);
    check("queue_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/kmeans_centroid_update_k7.md
Name: kmeans_centroid_update_k7

Overview:
Consumer side of the k-means accumulation interface. It receives the 7 per-cluster coordinate sums and point counts together with the update_centroids strobe, and computes the new centroid means (sum / count) for every cluster and axis. The division is a sequential restoring divider, shared across all 21 quotients. The block holds the current centroid set that feeds the distance unit and commits all 21 new values atomically.

Parameters:
INIT_CX, 56'hD0_B0_90_70_50_30_10, initial x centroids, 8 bits per cluster, cluster 0 in bits [7:0]
INIT_CY, 56'hD0_B0_90_70_50_30_10, initial y centroids, same packing
INIT_CZ, 56'hD0_B0_90_70_50_30_10, initial z centroids, same packing

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
update_centroids  input  1  single-cycle strobe; sums and counts are valid in this cycle
sumx0..sumx6  input  16 each  per-cluster x sum
sumy0..sumy6  input  16 each  per-cluster y sum
sumz0..sumz6  input  16 each  per-cluster z sum
cnt0..cnt6  input  6 each  per-cluster point count
cx0..cx6  output  8 each  current x centroids
cy0..cy6  output  8 each  current y centroids
cz0..cz6  output  8 each  current z centroids
busy  output  1  division sequence in progress
upd_done  output  1  one-cycle pulse; new centroid set committed
changed  output  1  last commit altered at least one centroid
overrun  output  1  sticky; a strobe arrived while busy

Behaviour:
- Reset (rst_n=0 at an edge):
  - cx/cy/cz take the INIT_* bytes.
  - busy=0, upd_done=0, changed=0, overrun=0, state=IDLE.
  - Any division in flight is discarded; no partial commit occurs.
- States:
  - IDLE, LOAD, SHIFT, WRITE.
  - Divisions run in order: cluster 0..6, and within each cluster x, y, z. This gives index j=0..20.
- IDLE:
  - If update_centroids=1 at edge T, all 28 inputs are captured into snapshot registers. State goes to LOAD with j=0.
  - Inputs are not sampled at any other time.
- LOAD (1 cycle):
  - Remainder=0, dividend=snapshot sum(j), divisor=snapshot cnt of cluster(j), bit counter=16.
- SHIFT (exactly 16 cycles):
  - Restoring step each cycle: remainder = {remainder, dividend MSB}; dividend shifts left.
  - If remainder >= divisor: subtract, quotient bit=1; otherwise quotient bit=0.
  - Remainder is 17 bits wide.
- WRITE (1 cycle):
  - Stores the result in pending slot j.
  - Result is truncated quotient, saturated to 8'hFF if the quotient exceeds 255.
  - If cnt=0, the pending slot gets the current centroid unchanged; the divider still spends the full 18 cycles.
  - Then j+1 → LOAD, or after j=20 → IDLE.
- Fixed latency, independent of data:
  - 21 × 18 = 378 cycles.
  - busy=1 exactly during cycles T+1..T+378.
- Commit, at the edge ending the final WRITE:
  - All 21 outputs load from the pending slots simultaneously.
  - upd_done=1 for cycle T+379 only; busy=0 in that cycle.
  - changed=1 if any pending value differs from the prior output, else 0. It holds until the next commit.
- Centroid outputs never change except at commit or reset.
- A strobe while busy is ignored: no restart and no resample. It sets overrun=1, which clears only on reset.
- A strobe in the upd_done cycle (state IDLE) is accepted normally.
- Widths:
  - Sums up to 65535 and counts up to 63 are handled exactly.
  - A count of 41 with 8-bit coordinates never saturates.

Test Plan:
- Reset release, no strobe → cx0=0x10, cx6=0xD0 (likewise cy/cz); busy=0, upd_done=0, changed=0, overrun=0.
- Strobe with sumx0=1000, sumy0=500, sumz0=41, cnt0=10, all other cnt=0 → upd_done at exactly T+379; cx0=100, cy0=50, cz0=4 (truncated); clusters 1..6 unchanged; changed=1.
- Repeat the previous strobe with identical inputs → centroids unchanged, changed=0.
- Strobe with sumx3=10455, cnt3=41 → cx3=255; sumx3=600, cnt3=1 → cx3=0xFF (saturate).
- Second strobe at T+100 → ignored; overrun=1; results and upd_done timing match the first strobe only.
- rst_n=0 at T+200 mid-sequence → busy=0, outputs back to INIT values, no upd_done pulse; a new strobe afterwards completes normally.
